// File: rtl/n64a_gamma_pkg.sv
// -----------------------------------------------------------------------------
// n64a_gamma_pkg
//
// Shared definitions for the video demux gamma lookup table.
//   - Table geometry: 4 pages x 128 entries x 7 bits, addressed {page, colour}.
//   - Page index constants, one per gamma curve (0.8, 0.9, 1.1, 1.2).
//   - gamma_build_image(): elaboration-time generator for the whole table,
//     in exact integer arithmetic, so the ROM has no external image file
//     and no entry can ever be left uninitialised.
//   - gamma_golden(): floating-point form of the curve, for reference models.
//
// Curve: entry = floor(127 * (a/127)^(1/g) + 0.5), with a = colour value and
// g = gamma of the page.
// -----------------------------------------------------------------------------
package n64a_gamma_pkg;

    localparam int GAMMA_ADDR_W    = 9;
    localparam int GAMMA_DATA_W    = 7;
    localparam int GAMMA_PAGES     = 4;
    localparam int GAMMA_PAGE_SIZE = 2 ** GAMMA_DATA_W;
    localparam int GAMMA_WORDS     = GAMMA_PAGES * GAMMA_PAGE_SIZE;
    localparam int GAMMA_MAX       = GAMMA_PAGE_SIZE - 1;

    localparam logic [1:0] GAMMA_P08 = 2'd0;
    localparam logic [1:0] GAMMA_P09 = 2'd1;
    localparam logic [1:0] GAMMA_P11 = 2'd2;
    localparam logic [1:0] GAMMA_P12 = 2'd3;

    typedef logic [GAMMA_DATA_W-1:0] gamma_word_t;

    // Wide enough for (2*127)^11 * 127^10, the largest product formed below.
    localparam int POW_W = 192;
    typedef logic [POW_W-1:0] pow_t;

    // Each gamma is held as an exact ratio num/den.
    function automatic int gamma_num(input logic [1:0] page);
        case (page)
            GAMMA_P08: return 4;    // 0.8 = 4/5
            GAMMA_P09: return 9;    // 0.9 = 9/10
            GAMMA_P11: return 11;   // 1.1 = 11/10
            default:   return 6;    // 1.2 = 6/5
        endcase
    endfunction

    function automatic int gamma_den(input logic [1:0] page);
        case (page)
            GAMMA_P08: return 5;
            GAMMA_P09: return 10;
            GAMMA_P11: return 10;
            default:   return 5;
        endcase
    endfunction

    function automatic pow_t ipow(input int base, input int e);
        pow_t r;
        r = pow_t'(1);
        for (int i = 0; i < e; i++) begin
            r = r * pow_t'(base);
        end
        return r;
    endfunction

    // With g = n/d and t = 127*(a/127)^(d/n), the entry is the largest y with
    // y - 0.5 <= t. Raising both sides to the n-th power (all terms are
    // non-negative) gives the integer test
    //   (2y-1)^n * 127^d <= a^d * 254^n
    // which is monotonic in y, so a binary search over 0..127 finds it.
    function automatic gamma_word_t gamma_entry_exact(input logic [1:0] page, input int a);
        int   n;
        int   d;
        int   lo;
        int   hi;
        int   mid;
        pow_t rhs;
        pow_t k;
        n   = gamma_num(page);
        d   = gamma_den(page);
        rhs = ipow(a, d) * ipow(2 * GAMMA_MAX, n);
        k   = ipow(GAMMA_MAX, d);
        lo  = 0;
        hi  = GAMMA_MAX;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (ipow(2 * mid - 1, n) * k <= rhs) begin
                lo = mid;
            end else begin
                hi = mid - 1;
            end
        end
        return gamma_word_t'(lo);
    endfunction

    // Whole table packed as word[i] = image[i*DATA_W +: DATA_W].
    function automatic logic [GAMMA_WORDS*GAMMA_DATA_W-1:0] gamma_build_image();
        logic [GAMMA_WORDS*GAMMA_DATA_W-1:0] img;
        img = '0;
        for (int i = 0; i < GAMMA_WORDS; i++) begin
            img[i*GAMMA_DATA_W +: GAMMA_DATA_W] =
                gamma_entry_exact(2'(i / GAMMA_PAGE_SIZE), i % GAMMA_PAGE_SIZE);
        end
        return img;
    endfunction

    // Floating-point form of the same curve.
    function automatic int gamma_golden(input logic [1:0] page, input int a);
        real g;
        real x;
        case (page)
            GAMMA_P08: g = 0.8;
            GAMMA_P09: g = 0.9;
            GAMMA_P11: g = 1.1;
            default:   g = 1.2;
        endcase
        x = real'(a) / real'(GAMMA_MAX);
        return int'($floor(real'(GAMMA_MAX) * (x ** (1.0 / g)) + 0.5));
    endfunction

endpackage

// File: rtl/gamma_rom_1port.sv
// -----------------------------------------------------------------------------
// gamma_rom_1port
//
// Synchronous single-port read-only gamma table for the video demux path.
// 4 pages x 128 entries x 7 bits; the demux clocks it on the inverted pixel
// clock so the registered result is ready for its next edge.
//
// Ports:
//   clock    in   1       ROM clock, rising edge active
//   nRST     in   1       asynchronous active-low reset, clears q
//   address  in   ADDR_W  [8:7] gamma page, [6:0] linear colour value
//   rden     in   1       read enable; q only updates on enabled edges
//   q        out  DATA_W  registered gamma-corrected colour
//
// Configuration macro:
//   GAMMA_ROM_OUTREG_EN  adds a second output register (read latency 2);
//                        both stages advance only on rden and clear on nRST.
//                        Undefined by default: latency 1.
//
// Table contents are generated at elaboration from the gamma curve, so there
// is no image file to go missing and no entry can read back as X.
// -----------------------------------------------------------------------------
module gamma_rom_1port
    import n64a_gamma_pkg::*;
#(
    parameter int ADDR_W = GAMMA_ADDR_W,
    parameter int DATA_W = GAMMA_DATA_W
) (
    input  logic              clock,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] address,
    input  logic              rden,
    output logic [DATA_W-1:0] q
);

    localparam int WORDS = 2 ** ADDR_W;
    localparam logic [WORDS*DATA_W-1:0] ROM_IMAGE = gamma_build_image();

    logic [DATA_W-1:0] rom [WORDS];

    for (genvar i = 0; i < WORDS; i++) begin : g_rom
        assign rom[i] = ROM_IMAGE[i*DATA_W +: DATA_W];
    end

    logic [DATA_W-1:0] rd_data;

    // NOTE: only the read register is reset; the table itself is constant
    // storage, and resetting an array would stop it mapping onto ROM.
    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            rd_data <= '0;
        end else if (rden) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            rd_data <= rom[address];
        end
    end

`ifdef GAMMA_ROM_OUTREG_EN
    logic [DATA_W-1:0] out_data;

    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            out_data <= '0;
        end else if (rden) begin
            out_data <= rd_data;
        end
    end

    assign q = out_data;
`else
    assign q = rd_data;
`endif

endmodule

// File: tb/tb_gamma_rom_1port.sv
// -----------------------------------------------------------------------------
// tb_gamma_rom_1port
//
// Self-checking bench for gamma_rom_1port. A floating-point model of the
// gamma curve (gamma_golden) predicts q on every falling clock edge; directed
// sequences add literal expectations for reset, spot values, rden gating,
// asynchronous reset and a full 512-address sweep with monotonic checks.
// Honours GAMMA_ROM_OUTREG_EN (read latency 2 when defined).
// -----------------------------------------------------------------------------
module tb_gamma_rom_1port;
    import n64a_gamma_pkg::*;

`ifdef GAMMA_ROM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock   = 1'b0;
    logic       nRST    = 1'b1;
    logic [8:0] address = '0;
    logic       rden    = 1'b0;
    logic [6:0] q;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit cmp_en = 1'b0;

    int lit64   [4] = '{54, 59, 68, 72};
    int sweep_q [GAMMA_WORDS];
    int m_pipe  [LAT];

    gamma_rom_1port dut (
        .clock   (clock),
        .nRST    (nRST),
        .address (address),
        .rden    (rden),
        .q       (q)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: each enabled edge looks the current address up on the curve and
    // the answer appears LAT enabled edges later; reset empties everything.
    always @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < LAT; k++) m_pipe[k] <= 0;
        end else if (rden) begin
            m_pipe[0] <= gamma_golden(address[8:7], int'(address[6:0]));
            for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
        end
    end

    always @(negedge clock) begin
        if (cmp_en) check("stream_q", int'(q), m_pipe[LAT-1]);
    end

    task automatic drive(input logic [1:0] page, input logic [6:0] a, input logic en);
        @(negedge clock);
        address = {page, a};
        rden    = en;
    endtask

    // Hold the address with rden high for LAT edges, then check q.
    task automatic read_lit(input string name, input logic [1:0] page,
                            input logic [6:0] a, input int exp);
        drive(page, a, 1'b1);
        repeat (LAT) @(posedge clock);
        #1 check(name, int'(q), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model against hand-computed values.
        for (int p = 0; p < 4; p++) begin
            check("golden_a64",  gamma_golden(2'(p), 64),  lit64[p]);
            check("golden_a0",   gamma_golden(2'(p), 0),   0);
            check("golden_a127", gamma_golden(2'(p), 127), 127);
        end

        // Reset held with reads requested and clocks running.
        rden    = 1'b1;
        address = {GAMMA_P11, 7'd64};
        #2 nRST = 1'b0;
        #1 check("reset_async", int'(q), 0);
        cmp_en = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1 check("reset_hold", int'(q), 0);
        end
        @(negedge clock) nRST = 1'b1;
        @(posedge clock);
        #1 check("reset_first_edge", int'(q), (LAT == 1) ? 68 : 0);
        read_lit("reset_then_p2_a64", GAMMA_P11, 7'd64, 68);

        // Per-page spot values and end points.
        for (int p = 0; p < 4; p++) begin
            read_lit("spot_a64",  2'(p), 7'd64,  lit64[p]);
            read_lit("spot_a0",   2'(p), 7'd0,   0);
            read_lit("spot_a127", 2'(p), 7'd127, 127);
        end

        // rden gating: address changes are ignored while rden is low.
        read_lit("gate_load", GAMMA_P08, 7'd64, 54);
        drive(GAMMA_P12, 7'd127, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1 check("gate_hold", int'(q), 54);
        end
        read_lit("gate_resume", GAMMA_P12, 7'd127, 127);

        // Asynchronous reset between clock edges.
        read_lit("async_pre", GAMMA_P12, 7'd64, 72);
        #2 nRST = 1'b0;
        #1 check("async_clear", int'(q), 0);
        nRST = 1'b1;

        // Reset asserted on an enabled edge: reset wins.
        read_lit("simul_pre", GAMMA_P12, 7'd64, 72);
        drive(GAMMA_P09, 7'd100, 1'b1);
        @(posedge clock);
        nRST = 1'b0;
        #1 check("simul_reset", int'(q), 0);
        @(negedge clock) nRST = 1'b1;
        read_lit("simul_after", GAMMA_P09, 7'd100, gamma_golden(GAMMA_P09, 100));

        // Full back-to-back sweep of all 512 addresses.
        for (int i = 0; i < GAMMA_WORDS + LAT; i++) begin
            @(negedge clock);
            if (i >= LAT) sweep_q[i-LAT] = int'(q);
            if (i < GAMMA_WORDS) begin
                address = 9'(i);
                rden    = 1'b1;
            end
        end
        for (int i = 0; i < GAMMA_WORDS; i++) begin
            check("sweep", sweep_q[i], gamma_golden(2'(i / GAMMA_PAGE_SIZE), i % GAMMA_PAGE_SIZE));
            if (i % GAMMA_PAGE_SIZE != 0) begin
                check("monotonic", int'(sweep_q[i] >= sweep_q[i-1]), 1);
            end
        end

        @(negedge clock);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
